// File: rtl/apb_prio_intc.sv
// ---------------------------------------------------------------------------
// apb_prio_intc
//   APB-programmable priority interrupt controller. Up to 32 peripheral lines
//   are captured into a pending register (edge or level per source), qualified
//   by per-source enable, per-source priority and a global threshold, and the
//   highest-priority eligible source is presented to the processor until it
//   signals service complete.
//
// Parameters
//   NUM_INTR : number of interrupt sources (2..32)
//   PRIO_W   : priority field width; priority 0 is never serviced
//   ID_W     : width of the source index, 2**ID_W >= NUM_INTR
//
// Ports
//   pclk_i            : clock, rising edge
//   prst_i            : asynchronous active-high reset
//   psel_i/penable_i  : APB select / access phase
//   pwrite_i          : 1 = write, 0 = read
//   paddr_i[7:0]      : register word index
//   pwdata_i[31:0]    : write data
//   prdata_o[31:0]    : read data, valid in access phase, 0 otherwise
//   pready_o          : transfer complete (zero wait states)
//   pslverr_o         : access to an unmapped address
//   intr_active_i     : peripheral interrupt lines (synchronous to pclk_i)
//   intr_to_service_o : index of the presented source
//   intr_prio_o       : priority of the presented source
//   intr_valid_o      : a source is presented
//   intr_serviced_i   : one-cycle pulse, presented source is complete
//
// Register map (word index)
//   0..NUM_INTR-1 : PRIO[i]   [PRIO_W-1:0]
//   NUM_INTR      : ENABLE    [NUM_INTR-1:0]
//   NUM_INTR+1    : MODE      [NUM_INTR-1:0]  1 = edge, 0 = level
//   NUM_INTR+2    : PENDING   [NUM_INTR-1:0]  write-1-to-clear
//   NUM_INTR+3    : THRESH    [PRIO_W-1:0]
// ---------------------------------------------------------------------------
module apb_prio_intc #(
  parameter int unsigned NUM_INTR = 16,
  parameter int unsigned PRIO_W   = 4,
  parameter int unsigned ID_W     = 5
) (
  input  logic                pclk_i,
  input  logic                prst_i,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic                pwrite_i,
  input  logic [7:0]          paddr_i,
  input  logic [31:0]         pwdata_i,
  output logic [31:0]         prdata_o,
  output logic                pready_o,
  output logic                pslverr_o,
  input  logic [NUM_INTR-1:0] intr_active_i,
  output logic [ID_W-1:0]     intr_to_service_o,
  output logic [PRIO_W-1:0]   intr_prio_o,
  output logic                intr_valid_o,
  input  logic                intr_serviced_i
);

  localparam logic [7:0] A_ENABLE = 8'(NUM_INTR);
  localparam logic [7:0] A_MODE   = 8'(NUM_INTR + 1);
  localparam logic [7:0] A_PEND   = 8'(NUM_INTR + 2);
  localparam logic [7:0] A_THRESH = 8'(NUM_INTR + 3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SERVE,
    S_GAP
  } state_t;

  // Programmable registers
  logic [PRIO_W-1:0]   r_prio [NUM_INTR];
  logic [NUM_INTR-1:0] r_enable;
  logic [NUM_INTR-1:0] r_mode;
  logic [NUM_INTR-1:0] r_pending;
  logic [PRIO_W-1:0]   r_thresh;
  logic [NUM_INTR-1:0] r_hist;

  // Presentation state
  state_t              r_state;
  logic                r_valid;
  logic [ID_W-1:0]     r_svc_id;
  logic [PRIO_W-1:0]   r_svc_prio;

  // APB decode
  logic                w_access;
  logic                w_bad;
  logic                w_wr;

  // Pending / arbitration
  logic [NUM_INTR-1:0] w_w1c;
  logic [NUM_INTR-1:0] w_rise;
  logic [NUM_INTR-1:0] w_svc_clr;
  logic [NUM_INTR-1:0] w_pend_nxt;
  logic [NUM_INTR-1:0] w_elig;
  logic                w_svc_done;
  logic                w_win_any;
  logic [ID_W-1:0]     w_win_id;
  logic [PRIO_W-1:0]   w_win_prio;

  // Upper write-data bits beyond the register widths carry no state.
  logic                w_unused;
  assign w_unused = ^pwdata_i;

  // -------------------------------------------------------------------------
  // APB access decode
  // -------------------------------------------------------------------------
  assign w_access  = psel_i & penable_i;
  assign w_bad     = (paddr_i > A_THRESH);
  assign w_wr      = w_access & pwrite_i & ~w_bad;
  assign pready_o  = w_access;
  assign pslverr_o = w_access & w_bad;

  always_comb begin
    prdata_o = '0;
    if (w_access && !w_bad) begin
      for (int unsigned i = 0; i < NUM_INTR; i++) begin
        if (paddr_i == 8'(i)) begin
          prdata_o[PRIO_W-1:0] = r_prio[i];
        end
      end
      if (paddr_i == A_ENABLE) prdata_o[NUM_INTR-1:0] = r_enable;
      if (paddr_i == A_MODE)   prdata_o[NUM_INTR-1:0] = r_mode;
      if (paddr_i == A_PEND)   prdata_o[NUM_INTR-1:0] = r_pending;
      if (paddr_i == A_THRESH) prdata_o[PRIO_W-1:0]   = r_thresh;
    end
  end

  // -------------------------------------------------------------------------
  // Pending capture
  //   Edge sources: a rising edge sets the bit and wins over both the
  //   write-1-to-clear and the service-complete clear in the same cycle.
  //   Level sources simply follow the line.
  // -------------------------------------------------------------------------
  assign w_svc_done = (r_state == S_SERVE) & intr_serviced_i;

  always_comb begin
    w_w1c = '0;
    if (w_wr && (paddr_i == A_PEND)) begin
      w_w1c = pwdata_i[NUM_INTR-1:0];
    end
    w_rise    = intr_active_i & ~r_hist;
    w_svc_clr = '0;
    for (int unsigned i = 0; i < NUM_INTR; i++) begin
      if (w_svc_done && (r_svc_id == ID_W'(i))) begin
        w_svc_clr[i] = 1'b1;
      end
    end
    w_pend_nxt = (r_mode & (w_rise | (r_pending & ~(w_w1c | w_svc_clr))))
               | (~r_mode & intr_active_i);
  end

  // -------------------------------------------------------------------------
  // Eligibility and arbitration: highest priority wins; scanning upward and
  // replacing only on a strictly higher priority keeps the lowest index on
  // ties.
  // -------------------------------------------------------------------------
  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < NUM_INTR; i++) begin
      w_elig[i] = r_pending[i] & r_enable[i] & (r_prio[i] > r_thresh)
                & ~(r_valid & (r_svc_id == ID_W'(i)));
    end
  end

  always_comb begin
    w_win_any  = 1'b0;
    w_win_id   = '0;
    w_win_prio = '0;
    for (int unsigned i = 0; i < NUM_INTR; i++) begin
      if (w_elig[i] && (!w_win_any || (r_prio[i] > w_win_prio))) begin
        w_win_any  = 1'b1;
        w_win_id   = ID_W'(i);
        w_win_prio = r_prio[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Register file, pending bits and edge history
  // -------------------------------------------------------------------------
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      for (int unsigned i = 0; i < NUM_INTR; i++) begin
        r_prio[i] <= '0;
      end
      r_enable  <= '0;
      r_mode    <= '0;
      r_pending <= '0;
      r_thresh  <= '0;
      r_hist    <= '0;
    end else begin
      r_hist    <= intr_active_i;
      r_pending <= w_pend_nxt;
      if (w_wr) begin
        for (int unsigned i = 0; i < NUM_INTR; i++) begin
          if (paddr_i == 8'(i)) begin
            r_prio[i] <= pwdata_i[PRIO_W-1:0];
          end
        end
        if (paddr_i == A_ENABLE) r_enable <= pwdata_i[NUM_INTR-1:0];
        if (paddr_i == A_MODE)   r_mode   <= pwdata_i[NUM_INTR-1:0];
        if (paddr_i == A_THRESH) r_thresh <= pwdata_i[PRIO_W-1:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Presentation FSM: the presented source is latched and held without
  // preemption; S_GAP gives a level source one cycle to drop after service.
  // -------------------------------------------------------------------------
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      r_state    <= S_IDLE;
      r_valid    <= 1'b0;
      r_svc_id   <= '0;
      r_svc_prio <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win_any) begin
            r_svc_id   <= w_win_id;
            r_svc_prio <= w_win_prio;
            r_valid    <= 1'b1;
            r_state    <= S_SERVE;
          end
        end
        S_SERVE: begin
          if (intr_serviced_i) begin
            r_svc_id   <= '0;
            r_svc_prio <= '0;
            r_valid    <= 1'b0;
            r_state    <= S_GAP;
          end
        end
        S_GAP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign intr_to_service_o = r_svc_id;
  assign intr_prio_o       = r_svc_prio;
  assign intr_valid_o      = r_valid;

endmodule

// File: tb/tb_apb_prio_intc.sv
module tb_apb_prio_intc;

  localparam int N  = 16;
  localparam int PW = 4;
  localparam int IW = 5;
  localparam int A_EN   = 16;
  localparam int A_MODE = 17;
  localparam int A_PEND = 18;
  localparam int A_THR  = 19;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [7:0]    paddr = '0;
  logic [31:0]   pwdata = '0;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;
  logic [N-1:0]  active = '0;
  logic [IW-1:0] iid;
  logic [PW-1:0] iprio;
  logic          ivalid;
  logic          serviced = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  bit           acc_act_en = 1'b0;
  logic [N-1:0] acc_act    = '0;

  always #5 clk = ~clk;

  apb_prio_intc #(.NUM_INTR(N), .PRIO_W(PW), .ID_W(IW)) dut (
    .pclk_i            (clk),
    .prst_i            (rst),
    .psel_i            (psel),
    .penable_i         (penable),
    .pwrite_i          (pwrite),
    .paddr_i           (paddr),
    .pwdata_i          (pwdata),
    .prdata_o          (prdata),
    .pready_o          (pready),
    .pslverr_o         (pslverr),
    .intr_active_i     (active),
    .intr_to_service_o (iid),
    .intr_prio_o       (iprio),
    .intr_valid_o      (ivalid),
    .intr_serviced_i   (serviced)
  );

  // Reference model: register contents plus "what is presented" and
  // "are we in the post-service gap", advanced once per clock edge.
  int unsigned m_prio [N];
  logic [N-1:0] m_en, m_mode, m_pend, m_hist;
  int unsigned  m_thr;
  bit           m_valid, m_gap;
  int unsigned  m_id, m_pr;

  always @(posedge clk or posedge rst) begin : mdl
    logic [N-1:0] np;
    logic [N-1:0] clr;
    bit           wr;
    int unsigned  mx;
    int unsigned  wid;
    bit           found;
    if (rst) begin
      for (int i = 0; i < N; i++) m_prio[i] <= 0;
      m_en <= '0; m_mode <= '0; m_pend <= '0; m_hist <= '0; m_thr <= 0;
      m_valid <= 1'b0; m_gap <= 1'b0; m_id <= 0; m_pr <= 0;
    end else begin
      wr  = psel && penable && pwrite && (int'(paddr) <= A_THR);
      clr = '0;
      if (wr && int'(paddr) == A_PEND) clr = pwdata[N-1:0];
      if (m_valid && serviced) clr[m_id] = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (m_mode[i]) np[i] = (active[i] && !m_hist[i]) ? 1'b1 : (clr[i] ? 1'b0 : m_pend[i]);
        else           np[i] = active[i];
      end
      if (m_valid) begin
        if (serviced) begin
          m_valid <= 1'b0; m_id <= 0; m_pr <= 0; m_gap <= 1'b1;
        end
      end else if (m_gap) begin
        m_gap <= 1'b0;
      end else begin
        mx = 0;
        for (int i = 0; i < N; i++)
          if (m_pend[i] && m_en[i] && m_prio[i] > m_thr && m_prio[i] > mx) mx = m_prio[i];
        if (mx != 0) begin
          found = 1'b0;
          wid   = 0;
          for (int i = 0; i < N; i++)
            if (!found && m_pend[i] && m_en[i] && m_prio[i] == mx) begin
              found = 1'b1;
              wid   = i;
            end
          m_valid <= 1'b1; m_id <= wid; m_pr <= mx;
        end
      end
      m_pend <= np;
      m_hist <= active;
      if (wr) begin
        if (int'(paddr) < N)         m_prio[int'(paddr)] <= pwdata & 32'hF;
        else if (int'(paddr) == A_EN)   m_en   <= pwdata[N-1:0];
        else if (int'(paddr) == A_MODE) m_mode <= pwdata[N-1:0];
        else if (int'(paddr) == A_THR)  m_thr  <= pwdata & 32'hF;
      end
    end
  end

  function automatic logic [31:0] mrd(input int a);
    if (a < N)       return 32'(m_prio[a]);
    if (a == A_EN)   return 32'(m_en);
    if (a == A_MODE) return 32'(m_mode);
    if (a == A_PEND) return 32'(m_pend);
    if (a == A_THR)  return 32'(m_thr);
    return 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("valid", 32'(ivalid), 32'(m_valid));
    chk("id",    32'(iid),    32'(m_id));
    chk("prio",  32'(iprio),  32'(m_pr));
  endtask

  task automatic pres(input int id, input int pr);
    chk("pres_valid", 32'(ivalid), 32'd1);
    chk("pres_id",    32'(iid),    32'(id));
    chk("pres_prio",  32'(iprio),  32'(pr));
  endtask

  task automatic none();
    chk("no_pres", 32'(ivalid), 32'd0);
  endtask

  task automatic apb(input bit wr, input int a, input logic [31:0] d,
                     input bit kuse, input logic [31:0] k);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = 8'(a); pwdata = d;
    #1;
    chk("pready_setup", 32'(pready), 32'd0);
    tick();
    penable = 1'b1;
    if (acc_act_en) active = acc_act;
    #1;
    chk("pready", 32'(pready), 32'd1);
    chk($sformatf("pslverr@%0d", a), 32'(pslverr), 32'(a > A_THR));
    if (!wr) begin
      chk($sformatf("rd@%0d", a), prdata, mrd(a));
      if (kuse) chk($sformatf("rdk@%0d", a), prdata, k);
    end
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wrr(input int a, input logic [31:0] d);
    apb(1'b1, a, d, 1'b0, 32'h0);
  endtask

  task automatic rd(input int a);
    apb(1'b0, a, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic rdk(input int a, input logic [31:0] k);
    apb(1'b0, a, 32'h0, 1'b1, k);
  endtask

  task automatic svc(input logic [N-1:0] act_after);
    active = act_after;
    serviced = 1'b1;
    tick();
    serviced = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit got;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid",   32'(ivalid),  32'd0);
    chk("rst_id",      32'(iid),     32'd0);
    chk("rst_prio",    32'(iprio),   32'd0);
    chk("rst_prdata",  prdata,       32'd0);
    chk("rst_pready",  32'(pready),  32'd0);
    chk("rst_pslverr", 32'(pslverr), 32'd0);
    rst = 1'b0;
    tick();

    // Priority arbitration and level re-evaluation after service
    wrr(3, 5); wrr(7, 9); wrr(A_EN, 32'hFFFF); wrr(A_MODE, 0);
    active = 16'h0088;
    tick(); none();
    tick(); pres(7, 9);
    svc(16'h0008);
    none();
    tick(); none();
    tick(); pres(3, 5);
    svc(16'h0000);
    tick(); tick(); none();

    // Equal priority: lowest index wins
    wrr(2, 4); wrr(9, 4);
    active = 16'h0204;
    tick(); tick(); pres(2, 4);
    svc(16'h0200);
    tick(); tick(); pres(9, 4);
    svc(16'h0000);
    tick(); tick();

    // Edge mode capture and write-1-to-clear
    wrr(5, 3); wrr(A_EN, 32'hFFDF); wrr(A_MODE, 32'h20);
    active = 16'h0020; tick(); active = 16'h0000; tick();
    rdk(A_PEND, 32'h20);
    wrr(A_PEND, 32'h20);
    rdk(A_PEND, 32'h0);
    wrr(A_EN, 32'hFFFF);
    tick(); tick(); tick(); none();
    active = 16'h0020; tick(); active = 16'h0000; tick();
    pres(5, 3);
    svc(16'h0000);
    rdk(A_PEND, 32'h0);
    tick(); tick();

    // A rising edge during the clear write keeps the bit set
    wrr(A_EN, 32'hFFDF);
    acc_act_en = 1'b1; acc_act = 16'h0020;
    wrr(A_PEND, 32'h20);
    acc_act_en = 1'b0;
    rdk(A_PEND, 32'h20);
    active = 16'h0000;
    wrr(A_PEND, 32'h20);
    rdk(A_PEND, 32'h0);
    wrr(A_EN, 32'hFFFF);
    tick(); none();

    // Threshold is strict; enable gates eligibility
    wrr(A_THR, 6); wrr(1, 6);
    active = 16'h0002;
    tick(); tick(); tick(); none();
    wrr(1, 7);
    tick(); pres(1, 7);
    svc(16'h0000);
    tick(); tick();
    wrr(A_EN, 32'hFFFD);
    active = 16'h0002;
    tick(); tick(); tick(); none();
    active = 16'h0000;
    wrr(A_EN, 32'hFFFF);
    wrr(A_THR, 0);
    tick();

    // Out-of-range accesses
    rdk(A_THR + 1, 32'h0);
    wrr(A_THR + 1, 32'hFFFF_FFFF);
    rdk(255, 32'h0);
    for (int a = 0; a <= A_THR; a++) rd(a);

    // Randomised traffic against the model
    for (int it = 0; it < 400; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 6) begin
        for (int b = 0; b < N; b++)
          if ($urandom_range(0, 7) == 0) active[b] = ~active[b];
        serviced = ivalid ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
        tick();
        serviced = 1'b0;
      end else begin
        int a;
        logic [31:0] d;
        a = $urandom_range(0, A_THR + 2);
        d = $urandom;
        if (a == A_THR) d = $urandom_range(0, 5);
        acc_act_en = ($urandom_range(0, 1) == 1);
        acc_act = active ^ N'($urandom & $urandom & $urandom);
        apb(op < 8, a, d, 1'b0, 32'h0);
        acc_act_en = 1'b0;
      end
    end

    // Asynchronous reset while a source is presented
    serviced = 1'b0; active = '0;
    wrr(A_THR, 0); wrr(A_MODE, 0); wrr(A_EN, 32'hFFFF); wrr(3, 5);
    active = 16'h0008;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      if (ivalid && iid == 5'd3) got = 1'b1;
      else begin
        serviced = ivalid;
        tick();
        serviced = 1'b0;
      end
    end
    chk("wait_src3", 32'(got), 32'd1);
    #2;
    rst = 1'b1;
    active = '0;
    #1;
    chk("arst_valid", 32'(ivalid), 32'd0);
    chk("arst_id",    32'(iid),    32'd0);
    chk("arst_prio",  32'(iprio),  32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    tick();
    for (int a = 0; a <= A_THR; a++) rdk(a, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_prio_intc.md
# apb_prio_intc

Parametrised, APB-programmable priority interrupt controller, the next generation of the team's 16-source fixed-format controller. It sits between up to 32 peripheral interrupt lines and the processor. It adds per-source enable masks, per-source edge/level mode, a pending register with write-1-to-clear, a global priority threshold, configurable priority width, and out-of-range slave-error reporting. It presents one winning interrupt at a time to the processor and holds it until the processor signals service complete.

## Interface
- NUM_INTR, 16: number of sources, 2..32.
- PRIO_W, 4: priority field width; 0 means never serviced.
- ID_W, 5: width of the source index; must satisfy 2^ID_W >= NUM_INTR.
- pclk_i  in  1  clock; all logic on the rising edge.
- prst_i  in  1  reset, asynchronous, active-high.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable (access phase).
- pwrite_i  in  1  1 = write, 0 = read.
- paddr_i  in  8  word index into the register map.
- pwdata_i  in  32  write data.
- prdata_o  out  32  read data.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  error on the transfer.
- intr_active_i  in  NUM_INTR  peripheral interrupt lines, synchronous to pclk_i.
- intr_to_service_o  out  ID_W  index of the presented source.
- intr_prio_o  out  PRIO_W  priority of the presented source.
- intr_valid_o  out  1  a source is presented.
- intr_serviced_i  in  1  single-cycle pulse: presented source is complete.

## Operation
- Register map (paddr_i):
  - 0..NUM_INTR-1: PRIO[i], bits [PRIO_W-1:0].
  - NUM_INTR: ENABLE mask.
  - NUM_INTR+1: MODE mask; 1 = edge, 0 = level.
  - NUM_INTR+2: PENDING; read returns the pending bits, write-1-to-clear.
  - NUM_INTR+3: THRESH, bits [PRIO_W-1:0].
  - Unused read bits are 0. All registers reset to 0.
- APB rules:
  - Zero wait states: pready_o = psel_i & penable_i.
  - Writes commit on the access-phase clock edge.
  - prdata_o is valid during the access phase and 0 otherwise.
  - An address above NUM_INTR+3 drives pslverr_o=1 for that access phase; the write is ignored and the read returns 0.
- Pending capture:
  - Edge mode: pending[i] sets on a 0→1 transition of intr_active_i[i], detected against a registered copy of the line.
  - Level mode: pending[i] = intr_active_i[i] each cycle.
- Eligibility: eligible[i] = pending[i] & ENABLE[i] & (PRIO[i] > THRESH) & (i is not the source in service).
- Arbitration: the highest PRIO wins; ties go to the lowest index.
- FSM, 3 states:
  - S_IDLE: if any source is eligible, register the winner into intr_to_service_o and intr_prio_o, set intr_valid_o=1, go to S_SERVE.
  - S_SERVE: outputs hold, with no preemption even if a higher-priority source arrives or the source is disabled. On intr_serviced_i: clear the edge-mode pending bit of the served source, set intr_valid_o=0, intr_to_service_o=0, intr_prio_o=0, go to S_GAP.
  - S_GAP: one cycle so a level source can deassert; then go to S_IDLE.
  - intr_serviced_i outside S_SERVE is ignored.
- Simultaneous events:
  - A set event beats write-1-to-clear and beats the service clear in the same cycle; the pending bit stays 1.
  - PRIO/THRESH/ENABLE writes affect arbitration from the next cycle only; the presented source is never altered.

## Timing
- Reset values: prdata_o=0, pready_o=0, pslverr_o=0, intr_to_service_o=0, intr_prio_o=0, intr_valid_o=0; FSM in S_IDLE; all registers and the edge history cleared.
- Reset asserted mid-service drops intr_valid_o immediately (asynchronously).
- Latency: line rises before edge k → pending=1 after edge k → intr_valid_o=1 after edge k+1.
- From the intr_serviced_i edge, the earliest next presentation is 2 edges later (S_GAP, then S_IDLE arbitration).

## Test plan
- PRIO[3]=5, PRIO[7]=9, ENABLE=0xFFFF, MODE=0. Raise lines 3 and 7 together → intr_valid_o=1 with intr_to_service_o=7, intr_prio_o=9 two cycles later. Service it, line 7 drops → source 3 presented 2 cycles after intr_serviced_i.
- PRIO[2]=PRIO[9]=4, lines 2 and 9 raised → source 2 presented (tie goes to the lowest index).
- MODE[5]=1, pulse line 5 high for 1 cycle → PENDING reads 0x20. Write 0x20 to PENDING → PENDING reads 0 and no interrupt is presented. Repeat with no clear → source 5 presented; after service PENDING reads 0.
- THRESH=6, PRIO[1]=6 → no presentation. Write PRIO[1]=7 → source 1 presented. With ENABLE[1]=0 instead → no presentation.
- Read paddr=NUM_INTR+4 → pready_o=1, pslverr_o=1, prdata_o=0. Write to that address changes no register.
- Assert prst_i while intr_valid_o=1 → intr_valid_o=0 with no clock edge, and all registers read 0 after release.
